// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial pattern detector:
// detection-mode encodings and the width helper for the fill counter.
package seq_det_pkg;

  // Detection modes, held in the mode register and loaded from cfg_mode.
  localparam logic MODE_OVERLAP    = 1'b0;
  localparam logic MODE_NONOVERLAP = 1'b1;

  // Width needed to hold a fill count ranging over 0..pat_w inclusive.
  function automatic int unsigned fill_width(input int unsigned pat_w);
    return $clog2(pat_w + 32'd1);
  endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear. The clear has priority
// over an increment in the same cycle; the count holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};
  localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
  localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear first, then a non-wrapping increment, else hold.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = CNT_ZERO;
    end else if (inc && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Count register, asynchronously cleared by the active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= CNT_ZERO;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector. A maskable, runtime-programmable
// PAT_W-bit pattern is compared against a qualified serial bit stream.
// The oldest bit of the window lines up with the pattern MSB. A hit
// produces a registered one-cycle pulse on out and bumps a saturating
// match counter. Overlapping or non-overlapping detection is selectable.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned      PAT_W    = 4,
  parameter int unsigned      CNT_W    = 8,
  parameter logic [PAT_W-1:0] DEF_PAT  = PAT_W'(4'b0110),
  parameter logic [PAT_W-1:0] DEF_MASK = {PAT_W{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic             in_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic [PAT_W-1:0] cfg_mask,
  input  logic             cfg_mode,
  input  logic             cnt_clr,
  output logic             out,
  output logic [CNT_W-1:0] match_count
);

  localparam int unsigned      FILL_W    = fill_width(PAT_W);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_ZERO = {FILL_W{1'b0}};
  localparam logic [FILL_W-1:0] FILL_ONE  = {{(FILL_W-1){1'b0}}, 1'b1};
  localparam logic [PAT_W-1:0]  PAT_ZERO  = {PAT_W{1'b0}};

  // Registered state.
  logic [PAT_W-1:0]  history_q;
  logic [PAT_W-1:0]  history_d;
  logic [FILL_W-1:0] fill_q;
  logic [FILL_W-1:0] fill_d;
  logic [PAT_W-1:0]  pat_q;
  logic [PAT_W-1:0]  pat_d;
  logic [PAT_W-1:0]  mask_q;
  logic [PAT_W-1:0]  mask_d;
  logic              mode_q;
  logic              mode_d;
  logic              out_q;
  logic              out_d;

  // Per-edge candidate values for an accepted bit.
  logic              accept_s;
  logic [PAT_W-1:0]  history_nx_s;
  logic [FILL_W-1:0] fill_inc_s;
  logic              hit_s;

  // A configuration load wins over a bit on the same edge; that bit is dropped.
  assign accept_s     = in_valid & ~cfg_load;
  assign history_nx_s = {history_q[PAT_W-2:0], in};

  // Fill count for an accepted bit, saturating once the window is full.
  always_comb begin
    fill_inc_s = fill_q;
    if (fill_q == FILL_FULL) begin
      fill_inc_s = fill_q;
    end else begin
      fill_inc_s = fill_q + FILL_ONE;
    end
  end

  // Match: the window must be full of bits accepted since the last
  // reconfiguration, and every cared-for bit must equal the pattern.
  always_comb begin
    hit_s = 1'b0;
    if (accept_s && (fill_inc_s == FILL_FULL)) begin
      hit_s = (((history_nx_s ^ pat_q) & mask_q) == PAT_ZERO);
    end else begin
      hit_s = 1'b0;
    end
  end

  // Next-state selection for config, shift window, fill count and pulse.
  always_comb begin
    history_d = history_q;
    fill_d    = fill_q;
    pat_d     = pat_q;
    mask_d    = mask_q;
    mode_d    = mode_q;
    out_d     = 1'b0;
    if (cfg_load) begin
      // New configuration: restart the fill so no match straddles the change.
      pat_d  = cfg_pat;
      mask_d = cfg_mask;
      mode_d = cfg_mode;
      fill_d = FILL_ZERO;
      out_d  = 1'b0;
    end else if (in_valid) begin
      out_d = hit_s;
      if (hit_s && (mode_q == MODE_NONOVERLAP)) begin
        // Non-overlapping: consume the matched window; PAT_W fresh bits needed.
        fill_d    = FILL_ZERO;
        history_d = history_q;
      end else begin
        history_d = history_nx_s;
        fill_d    = fill_inc_s;
      end
    end else begin
      // Gap in the stream: hold everything, drop the pulse.
      out_d = 1'b0;
    end
  end

  // Detector registers with asynchronous active-low reset to the defaults.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      history_q <= PAT_ZERO;
      fill_q    <= FILL_ZERO;
      pat_q     <= DEF_PAT;
      mask_q    <= DEF_MASK;
      mode_q    <= MODE_OVERLAP;
      out_q     <= 1'b0;
    end else begin
      history_q <= history_d;
      fill_q    <= fill_d;
      pat_q     <= pat_d;
      mask_q    <= mask_d;
      mode_q    <= mode_d;
      out_q     <= out_d;
    end
  end

  assign out = out_q;

  sat_counter #(
    .W (CNT_W)
  ) u_match_count (
    .clk   (clk),
    .reset (reset),
    .inc   (hit_s),
    .clr   (cnt_clr),
    .count (match_count)
  );

endmodule
